// File: rtl/id_ex_ctrl_stage.sv
// RV32I ID->EX control stage: decodes the IF/ID instruction into the EX control bundle,
// handles load-use bubbles, redirect flushes and cache holds. Optional macro: ID_EX_CTRL_RV32M_EN.
module id_ex_ctrl_stage #(
    parameter int ALU_CTRL_W = 5,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  brnch,
    input  logic                  cache_busy,
    output logic                  ex_valid,
    output logic [ALU_CTRL_W-1:0] aluCont,
    output logic                  rdEn,
    output logic                  DMwriteEn,
    output logic                  ex_memRead,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [1:0]            rdmuxSel,
    output logic                  alumux1sel,
    output logic                  alumux2sel,
    output logic [2:0]            imm,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  pcloadEn,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  illegal_instr
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [ALU_CTRL_W-1:0] alu_p0;
    logic       rden_p0, dmw_p0, mrd_p0, br_p0, jmp_p0, m1_p0, m2_p0, legal_p0;
    logic       rs1_used_p0, rs2_used_p0, hazard_p0, load_p0;
    logic [1:0] rdmux_p0;
    logic [2:0] imm_p0;

    // ---- decode (ID stage) ----
    always_comb begin
        alu_p0      = '0;
        rden_p0     = 1'b0;
        dmw_p0      = 1'b0;
        mrd_p0      = 1'b0;
        br_p0       = 1'b0;
        jmp_p0      = 1'b0;
        m1_p0       = 1'b0;
        m2_p0       = 1'b0;
        rdmux_p0    = 2'b00;
        imm_p0      = 3'b000;
        legal_p0    = 1'b1;
        rs1_used_p0 = 1'b0;
        rs2_used_p0 = 1'b0;
        case (opcode)
            OP_R: begin
                rs1_used_p0 = 1'b1;
                rs2_used_p0 = 1'b1;
                rden_p0     = 1'b1;
                if (func7 == 7'b0000000 || func7 == 7'b0100000) begin
                    alu_p0[3:0] = {func7[5], func3};
`ifdef ID_EX_CTRL_RV32M_EN
                end else if (func7 == 7'b0000001) begin
                    alu_p0[4]   = 1'b1;
                    alu_p0[2:0] = func3;
`endif
                end else begin
                    legal_p0 = 1'b0;
                end
            end
            OP_I: begin
                rs1_used_p0 = 1'b1;
                rden_p0     = 1'b1;
                m2_p0       = 1'b1;
                alu_p0[3:0] = {(func3 == 3'b101) ? func7[5] : 1'b0, func3};
                imm_p0      = (func3 == 3'b001 || func3 == 3'b101) ? 3'b101 : 3'b000;
            end
            OP_LOAD: begin
                rs1_used_p0 = 1'b1;
                rden_p0     = 1'b1;
                mrd_p0      = 1'b1;
                rdmux_p0    = 2'b01;
                m2_p0       = 1'b1;
            end
            OP_STORE: begin
                rs1_used_p0 = 1'b1;
                rs2_used_p0 = 1'b1;
                dmw_p0      = 1'b1;
                m2_p0       = 1'b1;
                imm_p0      = 3'b001;
            end
            OP_B: begin
                rs1_used_p0 = 1'b1;
                rs2_used_p0 = 1'b1;
                br_p0       = 1'b1;
                m1_p0       = 1'b1;
                m2_p0       = 1'b1;
                imm_p0      = 3'b010;
            end
            OP_JAL: begin
                jmp_p0   = 1'b1;
                rden_p0  = 1'b1;
                rdmux_p0 = 2'b10;
                m1_p0    = 1'b1;
                m2_p0    = 1'b1;
                imm_p0   = 3'b011;
            end
            OP_JALR: begin
                rs1_used_p0 = 1'b1;
                jmp_p0      = 1'b1;
                rden_p0     = 1'b1;
                rdmux_p0    = 2'b10;
                m2_p0       = 1'b1;
            end
            OP_LUI: begin
                rden_p0  = 1'b1;
                rdmux_p0 = 2'b11;
                imm_p0   = 3'b100;
            end
            OP_AUIPC: begin
                rden_p0 = 1'b1;
                m1_p0   = 1'b1;
                m2_p0   = 1'b1;
                imm_p0  = 3'b100;
            end
            default: legal_p0 = 1'b0;
        endcase
    end

    assign hazard_p0 = ex_valid && ex_memRead && (ex_rd != '0) && id_valid &&
                       ((ex_rd == rs1 && rs1_used_p0) || (ex_rd == rs2 && rs2_used_p0));
    assign pcloadEn  = ex_valid & (ex_jump | (ex_branch & brnch)) & ~cache_busy;
    assign flush_id  = pcloadEn;
    assign stall_id  = cache_busy | (hazard_p0 & ~pcloadEn);
    assign load_p0   = id_valid & legal_p0 & ~pcloadEn & ~hazard_p0;

    // ---- ID/EX register (EX stage) ----
    always_ff @(posedge clk) begin
        if (rst || (!cache_busy && !load_p0)) begin
            ex_valid   <= 1'b0;
            aluCont    <= '0;
            rdEn       <= 1'b0;
            DMwriteEn  <= 1'b0;
            ex_memRead <= 1'b0;
            ex_branch  <= 1'b0;
            ex_jump    <= 1'b0;
            rdmuxSel   <= 2'b00;
            alumux1sel <= 1'b0;
            alumux2sel <= 1'b0;
            imm        <= 3'b000;
            ex_rd      <= '0;
        end else if (!cache_busy) begin
            ex_valid   <= 1'b1;
            aluCont    <= alu_p0;
            rdEn       <= rden_p0;
            DMwriteEn  <= dmw_p0;
            ex_memRead <= mrd_p0;
            ex_branch  <= br_p0;
            ex_jump    <= jmp_p0;
            rdmuxSel   <= rdmux_p0;
            alumux1sel <= m1_p0;
            alumux2sel <= m2_p0;
            imm        <= imm_p0;
            ex_rd      <= rd;
        end
    end

`ifdef ID_EX_CTRL_RV32M_EN
    // Pulses only when an illegal instruction's bubble is actually loaded into EX.
    always_ff @(posedge clk) begin
        if (rst || cache_busy)
            illegal_instr <= 1'b0;
        else
            illegal_instr <= id_valid & ~legal_p0 & ~pcloadEn & ~hazard_p0;
    end
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
